mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one main-memory port between I-cache refills and D-cache refills/writebacks
module mem_port_arbiter #(
    parameter int          ADDR_W   = 28,
    parameter int          BLOCK_W  = 128,
    parameter logic [15:0] CNT_INIT = 16'h0000
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               i_read,
    input  logic [ADDR_W-1:0]  i_address,
    output logic [BLOCK_W-1:0] i_readdata,
    output logic               i_busywait,
    input  logic               d_read,
    input  logic               d_write,
    input  logic [ADDR_W-1:0]  d_address,
    input  logic [BLOCK_W-1:0] d_writedata,
    output logic [BLOCK_W-1:0] d_readdata,
    output logic               d_busywait,
    output logic               mem_read,
    output logic               mem_write,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [BLOCK_W-1:0] mem_writedata,
    input  logic [BLOCK_W-1:0] mem_readdata,
    input  logic               mem_busywait,
    output logic [15:0]        i_served_cnt,
    output logic [15:0]        d_served_cnt
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] GRANT_I   = 3'd1;
    localparam logic [2:0] GRANT_D   = 3'd2;
    localparam logic [2:0] RELEASE_I = 3'd3;
    localparam logic [2:0] RELEASE_D = 3'd4;

    logic [2:0]         state_q, state_d;
    logic               last_d_q, last_d_d;
    logic               wr_q, wr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [BLOCK_W-1:0] wdata_q, wdata_d;
    logic [BLOCK_W-1:0] i_rdata_q, i_rdata_d;
    logic [BLOCK_W-1:0] d_rdata_q, d_rdata_d;
    logic [15:0]        i_cnt_q, i_cnt_d;
    logic [15:0]        d_cnt_q, d_cnt_d;
    logic               d_pend, grant_i, in_grant, gnt_d;

    assign d_pend   = d_read | d_write;
    assign grant_i  = i_read && (!d_pend || last_d_q);
    assign in_grant = (state_q == GRANT_I) || (state_q == GRANT_D);
    assign gnt_d    = state_q == GRANT_D;

    always_comb begin
        state_d   = state_q;
        last_d_d  = last_d_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_cnt_d   = i_cnt_q;
        d_cnt_d   = d_cnt_q;
        if (state_q == IDLE && (i_read || d_pend)) begin
            state_d = grant_i ? GRANT_I : GRANT_D;
            wr_d    = !grant_i && d_write;
            addr_d  = grant_i ? i_address : d_address;
            wdata_d = grant_i ? '0 : d_writedata;
        end
        // state_q is entered on an edge, so any edge seen here follows a full cycle in GRANT
        if (in_grant && !mem_busywait) begin
            state_d   = gnt_d ? RELEASE_D : RELEASE_I;
            last_d_d  = gnt_d;
            i_rdata_d = gnt_d ? i_rdata_q : mem_readdata;
            d_rdata_d = (gnt_d && !wr_q) ? mem_readdata : d_rdata_q;
            i_cnt_d   = (gnt_d || &i_cnt_q) ? i_cnt_q : i_cnt_q + 16'd1;
            d_cnt_d   = (!gnt_d || &d_cnt_q) ? d_cnt_q : d_cnt_q + 16'd1;
        end
        if (state_q >= RELEASE_I) state_d = IDLE;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q   <= IDLE;
            last_d_q  <= 1'b1;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_cnt_q   <= CNT_INIT;
            d_cnt_q   <= CNT_INIT;
        end else begin
            state_q   <= state_d;
            last_d_q  <= last_d_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_cnt_q   <= i_cnt_d;
            d_cnt_q   <= d_cnt_d;
        end
    end

    assign mem_read      = in_grant && !wr_q;
    assign mem_write     = in_grant && wr_q;
    assign mem_address   = addr_q;
    assign mem_writedata = wdata_q;
    assign i_readdata    = i_rdata_q;
    assign d_readdata    = d_rdata_q;
    assign i_served_cnt  = i_cnt_q;
    assign d_served_cnt  = d_cnt_q;
    assign i_busywait    = i_read && (state_q != RELEASE_I);
    assign d_busywait    = d_pend && (state_q != RELEASE_D);
endmodule
